// File: rtl/packetizer_ta_pkg.sv
// rtl/packetizer_ta_pkg.sv - packet geometry constants and the flit packing function
package packetizer_ta_pkg;

    localparam int WIDTH_PKT_DEF        = 72;
    localparam int WIDTH_DATA_DEF       = 32;
    localparam int VC_ADDRESS_WIDTH_DEF = 1;
    localparam int ADDRESS_WIDTH_DEF    = 4;
    localparam int PACKETIZER_WIDTH_DEF = 4;
    localparam int TAG_WIDTH_DEF        = 5;

    localparam int HDR_W          = 3;
    localparam int FLIT_W         = WIDTH_PKT_DEF / PACKETIZER_WIDTH_DEF;
    localparam int HEAD_PAYLOAD_W = FLIT_W - HDR_W - ADDRESS_WIDTH_DEF
                                    - VC_ADDRESS_WIDTH_DEF - TAG_WIDTH_DEF;
    localparam int BODY_PAYLOAD_W = FLIT_W - HDR_W;

    // Upper bound on any packet or field width handled by pack_pkt.
    localparam int MAX_W = 256;
    typedef logic [MAX_W-1:0] wide_t;

    function automatic int payload_capacity(input int pkt_w, input int n,
                                            input int aw, input int vw, input int tw);
        return n * (pkt_w / n - HDR_W) - aw - vw - tw;
    endfunction

    // Returns the packet right-aligned in a wide_t; bit pkt_w-1 is the MSB of flit 0.
    // Payload bits are numbered k=0.. in stream order: dest, vc, tag, data, zero fill.
    function automatic wide_t pack_pkt(input wide_t data, input wide_t dest,
                                       input wide_t vc, input wide_t tag,
                                       input int pkt_w, input int n, input int dw,
                                       input int aw, input int vw, input int tw);
        wide_t pkt;
        int    flit_w;
        int    f;
        int    o;
        int    k;
        logic  b;
        pkt    = '0;
        flit_w = pkt_w / n;
        for (int p = 0; p < MAX_W; p++) begin
            if (p < pkt_w) begin
                f = p / flit_w;
                o = p % flit_w;
                k = f * (flit_w - HDR_W) + o - HDR_W;
                if (o == 0)                       b = 1'b1;
                else if (o == 1)                  b = (f == 0);
                else if (o == 2)                  b = (f == n - 1);
                else if (k < aw)                  b = dest[aw - 1 - k];
                else if (k < aw + vw)             b = vc[aw + vw - 1 - k];
                else if (k < aw + vw + tw)        b = tag[aw + vw + tw - 1 - k];
                else if (k < aw + vw + tw + dw)   b = data[aw + vw + tw + dw - 1 - k];
                else                              b = 1'b0;
                pkt[pkt_w - 1 - p] = b;
            end
        end
        return pkt;
    endfunction

endpackage

// File: rtl/pkt_skid_fifo2.sv
// rtl/pkt_skid_fifo2.sv - 2-entry FIFO with registered input ready
module pkt_skid_fifo2
    import packetizer_ta_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    // ready_q is only high below two entries, so a push can never overflow.
    assign push = in_valid_i && ready_q;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/packetizer_ta.sv
// rtl/packetizer_ta.sv - packs data/dest/vc/tag into N flits and buffers them for the NoC
module packetizer_ta
    import packetizer_ta_pkg::*;
#(
    parameter int WIDTH_PKT        = 72,
    parameter int WIDTH_DATA       = 32,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int PACKETIZER_WIDTH = 4,
    parameter int TAG_WIDTH        = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dest_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic [TAG_WIDTH-1:0]        tag_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
);

    if (!(PACKETIZER_WIDTH == 1 || PACKETIZER_WIDTH == 2 || PACKETIZER_WIDTH == 4)
        || (WIDTH_PKT % PACKETIZER_WIDTH) != 0
        || WIDTH_PKT >= MAX_W
        || payload_capacity(WIDTH_PKT, PACKETIZER_WIDTH, ADDRESS_WIDTH,
                            VC_ADDRESS_WIDTH, TAG_WIDTH) < WIDTH_DATA) begin : g_geom_err
        $error("packetizer_ta: illegal packet geometry");
    end

    wide_t                pkt_wide;
    logic [WIDTH_PKT-1:0] pkt;
    logic                 unused_hi;

    // The word is packed before it enters the FIFO, so the output path is register-only.
    always_comb begin
        pkt_wide = pack_pkt(wide_t'(data_in), wide_t'(dest_in), wide_t'(vc_in), wide_t'(tag_in),
                            WIDTH_PKT, PACKETIZER_WIDTH, WIDTH_DATA,
                            ADDRESS_WIDTH, VC_ADDRESS_WIDTH, TAG_WIDTH);
    end

    assign pkt       = pkt_wide[WIDTH_PKT-1:0];
    assign unused_hi = ^pkt_wide[MAX_W-1:WIDTH_PKT];

    pkt_skid_fifo2 #(
        .WIDTH (WIDTH_PKT)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .in_data_i   (pkt),
        .in_valid_i  (valid_in),
        .in_ready_o  (ready_out),
        .out_data_o  (data_out),
        .out_valid_o (valid_out),
        .out_ready_i (ready_in)
    );

endmodule

// File: tb/tb_packetizer_ta.sv
// tb/tb_packetizer_ta.sv - scoreboard bench for packetizer_ta with N=4, 2, 1
`timescale 1ns/1ps
module tb_packetizer_ta;

    localparam int PW = 72, DW = 32, VW = 1, AW = 4, TW = 5;
    localparam int NWORDS = 1000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
        logic [VW-1:0] vc;
        logic [TW-1:0] tag;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] din   [3];
    logic [AW-1:0] dst   [3];
    logic [VW-1:0] vci   [3];
    logic [TW-1:0] tgi   [3];
    logic          vin   [3];
    logic          rout  [3];
    logic [PW-1:0] dout  [3];
    logic          vout  [3];
    logic          rin   [3];

    word_t sb [3][$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Far-end depacketizer: strip 3 header bits per flit, concatenate payloads, split fields.
    task automatic decode(input int n, input logic [PW-1:0] pkt, output word_t w, output bit fmt_ok);
        int            fw;
        int            k;
        logic [PW-1:0] pl;
        logic [2:0]    hdr;
        logic [2:0]    hdr_exp;
        fw = PW / n;
        k = 0;
        pl = '0;
        fmt_ok = 1'b1;
        for (int f = 0; f < n; f++) begin
            hdr = pkt[PW-1-f*fw -: 3];
            hdr_exp = {1'b1, f == 0, f == n - 1};
            if (hdr != hdr_exp) fmt_ok = 1'b0;
            for (int b = 3; b < fw; b++) begin
                pl[PW-1-k] = pkt[PW-1-f*fw-b];
                k++;
            end
        end
        w.dest = pl[PW-1 -: AW];
        w.vc   = pl[PW-1-AW -: VW];
        w.tag  = pl[PW-1-AW-VW -: TW];
        w.data = pl[PW-1-AW-VW-TW -: DW];
        for (int i = AW + VW + TW + DW; i < k; i++) begin
            if (pl[PW-1-i]) fmt_ok = 1'b0;
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        w.data = DW'($urandom);
        w.dest = AW'($urandom);
        w.vc   = VW'($urandom);
        w.tag  = TW'($urandom);
        return w;
    endfunction

    task automatic drive(input int g, input word_t w);
        din[g] = w.data;
        dst[g] = w.dest;
        vci[g] = w.vc;
        tgi[g] = w.tag;
    endtask

    // Called at a negedge; returns at the negedge after the accepting clock edge.
    task automatic offer(input int g, input word_t w, input int max_wait, output int waited);
        drive(g, w);
        vin[g] = 1'b1;
        waited = 0;
        while (!rout[g] && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        if (rout[g]) begin
            sb[g].push_back(w);
            @(negedge clk);
        end else begin
            chk($sformatf("offer_timeout_g%0d", g), rout[g], 1);
        end
        vin[g] = 1'b0;
    endtask

    task automatic random_run(input int g);
        int    sent;
        int    cyc;
        bit    acc;
        word_t w;
        sent = 0;
        cyc = 0;
        acc = 1'b0;
        w = '0;
        vin[g] = 1'b0;
        while ((sent < NWORDS || sb[g].size() != 0) && cyc < 20000) begin
            if (acc) vin[g] = 1'b0;
            rin[g] = (sent >= NWORDS) || ($urandom_range(0, 3) != 0);
            if (!vin[g] && sent < NWORDS && $urandom_range(0, 4) != 0) begin
                w = rand_word();
                drive(g, w);
                vin[g] = 1'b1;
            end
            acc = vin[g] && rout[g];
            if (acc) begin
                sb[g].push_back(w);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        vin[g] = 1'b0;
        chk($sformatf("rand_sent_g%0d", g), sent, NWORDS);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : (g == 1) ? 2 : 1;

        packetizer_ta #(
            .WIDTH_PKT        (PW),
            .WIDTH_DATA       (DW),
            .VC_ADDRESS_WIDTH (VW),
            .ADDRESS_WIDTH    (AW),
            .PACKETIZER_WIDTH (NS),
            .TAG_WIDTH        (TW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .data_in   (din[g]),
            .dest_in   (dst[g]),
            .vc_in     (vci[g]),
            .tag_in    (tgi[g]),
            .valid_in  (vin[g]),
            .ready_out (rout[g]),
            .data_out  (dout[g]),
            .valid_out (vout[g]),
            .ready_in  (rin[g])
        );

        logic          prev_stall = 1'b0;
        logic [PW-1:0] prev_d = '0;

        // Monitor samples just before each rising edge, when inputs and outputs are settled.
        always @(negedge clk) begin
            word_t got_w;
            word_t exp_w;
            bit    ok;
            #4;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk($sformatf("stall_stable_n%0d", NS), {vout[g], dout[g]}, {1'b1, prev_d});
                end
                if (vout[g] && rin[g]) begin
                    chk($sformatf("pkt_expected_n%0d", NS), sb[g].size() != 0, 1);
                    if (sb[g].size() != 0) begin
                        exp_w = sb[g].pop_front();
                        decode(NS, dout[g], got_w, ok);
                        chk($sformatf("pkt_n%0d", NS), {ok, got_w}, {1'b1, exp_w});
                    end
                end
                prev_stall = vout[g] && !rin[g];
                prev_d = dout[g];
            end
        end
    end

    initial begin
        word_t w;
        word_t wa;
        word_t wb;
        word_t wc;
        word_t got;
        bit    ok;
        int    waited;
        logic [31:0] dword;

        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            din[g] = '0; dst[g] = '0; vci[g] = '0; tgi[g] = '0;
            vin[g] = 1'b0; rin[g] = 1'b0;
        end
        #1;
        chk("reset_valid", vout[0], 0);
        chk("reset_ready", rout[0], 0);
        chk("reset_data", dout[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", rout[0], 1);

        // Single word with known flit encoding.
        w.data = 32'hDEADBEEF; w.dest = 4'h5; w.vc = 1'b1; w.tag = 5'h13;
        dword = w.data;
        chk("t1_idle_valid", vout[0], 0);
        offer(0, w, 4, waited);
        chk("t1_latency_valid", vout[0], 1);
        chk("t1_flit0", dout[0][71:54], 18'h32E7B);
        chk("t1_flit1", dout[0][53:36], {3'b100, dword[26:12]});
        chk("t1_flit3_hdr", dout[0][17:15], 3'b101);
        rin[0] = 1'b1;
        @(negedge clk);
        rin[0] = 1'b0;
        chk("t1_popped", vout[0], 0);

        // Backpressure with three words offered.
        wa = rand_word(); wb = rand_word(); wc = rand_word();
        offer(0, wa, 4, waited);
        offer(0, wb, 4, waited);
        chk("t2_ready_low", rout[0], 0);
        drive(0, wc);
        vin[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_ready_held_low", rout[0], 0);
        end
        decode(4, dout[0], got, ok);
        chk("t2_head_is_a", {ok, got}, {1'b1, wa});
        rin[0] = 1'b1;
        @(negedge clk);
        chk("t2_ready_after_pop", rout[0], 1);
        offer(0, wc, 0, waited);
        repeat (3) @(negedge clk);
        chk("t2_drained", vout[0], 0);

        // Streaming at occupancy 1.
        rin[0] = 1'b0;
        offer(0, rand_word(), 4, waited);
        rin[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = rand_word();
            drive(0, w);
            vin[0] = 1'b1;
            chk($sformatf("t3_stream_%0d", i), {rout[0], vout[0]}, 2'b11);
            if (rout[0]) sb[0].push_back(w);
            @(negedge clk);
        end
        vin[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_drained", vout[0], 0);

        // Reset while full.
        rin[0] = 1'b0;
        offer(0, rand_word(), 4, waited);
        offer(0, rand_word(), 4, waited);
        chk("t4_full", {vout[0], rout[0]}, 2'b10);
        rst = 1'b0;
        #1;
        sb[0].delete();
        chk("t4_rst_valid", vout[0], 0);
        chk("t4_rst_ready", rout[0], 0);
        chk("t4_rst_data", dout[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rin[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_stale", {vout[0], rout[0]}, 2'b01);
        end

        // Random loopback on all three geometries.
        fork
            random_run(0);
            random_run(1);
            random_run(2);
        join
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("sb_empty_g%0d", g), sb[g].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
